// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the default operand width reused by the bench.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int WIDTH_DEF = 4;
  localparam int CNT_W_DEF = 5;

endpackage

// File: rtl/serial_subtractor_if.sv
// Request/response bundle for the serial subtractor; the master issues
// operands and start, the slave returns busy/done and the result.
interface serial_subtractor_if #(
  parameter int WIDTH = serial_sub_pkg::WIDTH_DEF
) ();

  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] D;
  logic             Bout;
  logic             V;

  modport master (
    output start, A, B, Bin,
    input  busy, done, D, Bout, V
  );

  modport slave (
    input  start, A, B, Bin,
    output busy, done, D, Bout, V
  );

endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor cell, the borrow counterpart of the full-adder cell.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: D = A - B - Bin over WIDTH clock cycles.
//   state | meaning
//   IDLE  | waiting for start; result outputs hold last value
//   SHIFT | one bit slice per edge, WIDTH edges total
//   DONE  | single cycle after completion; start ignored
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_subtractor_if.slave   bus
);

  state_t state, state_nxt;

  logic             busy_q, busy_nxt;
  logic             done_q, done_nxt;
  logic             load, shift_en, last;

  logic [WIDTH-1:0] a_sh, b_sh, d_sh, d_sh_nxt;
  logic             br;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH-1:0] d_q;
  logic             bout_q, v_q;

  logic             fs_d, fs_bout;

  full_subtractor u_fs (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .bin  (br),
    .d    (fs_d),
    .bout (fs_bout)
  );

  // Result register fills from the top so the LSB lands at bit 0 after WIDTH shifts.
  assign d_sh_nxt = (d_sh >> 1) | (WIDTH'(fs_d) << (WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      busy_q <= busy_nxt;
      done_q <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy_nxt  = busy_q;
    done_nxt  = 1'b0;
    load      = 1'b0;
    shift_en  = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          load      = 1'b1;
          busy_nxt  = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        shift_en = 1'b1;
        if (cnt == CNT_W'(WIDTH - 1)) begin
          last      = 1'b1;
          done_nxt  = 1'b1;
          busy_nxt  = 1'b0;
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      d_sh   <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      d_q    <= '0;
      bout_q <= 1'b0;
      v_q    <= 1'b0;
    end else if (load) begin
      a_sh <= bus.A;
      b_sh <= bus.B;
      br   <= bus.Bin;
      d_sh <= '0;
      cnt  <= '0;
    end else if (shift_en) begin
      a_sh <= a_sh >> 1;
      b_sh <= b_sh >> 1;
      br   <= fs_bout;
      d_sh <= d_sh_nxt;
      cnt  <= cnt + 1'b1;
      if (last) begin
        // On the final slice a_sh[0]/b_sh[0] are the original operand MSBs.
        d_q    <= d_sh_nxt;
        bout_q <= fs_bout;
        v_q    <= (a_sh[0] ^ b_sh[0]) & (a_sh[0] ^ fs_d);
      end
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.D    = d_q;
  assign bus.Bout = bout_q;
  assign bus.V    = v_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random checks of serial_subtractor against an arithmetic model.
module tb_serial_subtractor;
  localparam int W = serial_sub_pkg::WIDTH_DEF;
  localparam int M = 1 << W;

  logic clk = 1'b0;
  logic rst;
  int   n_assert = 0;
  int   n_fail   = 0;

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W), .CNT_W(serial_sub_pkg::CNT_W_DEF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model(input int a, input int b, input int bin,
                                output int d, output int bo, output int v);
    int diff, sa, sb, sres;
    diff = a - b - bin;
    d    = ((diff % M) + M) % M;
    bo   = (diff < 0) ? 1 : 0;
    sa   = (a >= M / 2) ? a - M : a;
    sb   = (b >= M / 2) ? b - M : b;
    sres = sa - sb - bin;
    v    = (sres < -(M / 2) || sres > M / 2 - 1) ? 1 : 0;
  endfunction

  // Called at posedge+#1 with the DUT idle. mode 1 pokes start during SHIFT,
  // mode 2 asserts start in the done cycle; both must be ignored.
  task automatic run_op(input int a, input int b, input int bin, input int mode, input string tag);
    int ed, eb, ev, lat;
    model(a, b, bin, ed, eb, ev);
    bus.A = W'(a); bus.B = W'(b); bus.Bin = bin[0]; bus.start = 1'b1;
    @(posedge clk); #1;
    check({tag, ".busy_acc"}, {31'd0, bus.busy}, 32'd1);
    if (mode == 1) begin
      bus.A = W'(1); bus.B = W'(1); bus.Bin = 1'b0; bus.start = 1'b1;
    end else begin
      bus.start = 1'b0;
    end
    lat = 0;
    while (bus.done !== 1'b1 && lat < 3 * W) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
      lat++;
    end
    check({tag, ".latency"}, lat, W);
    check({tag, ".D"}, {28'd0, bus.D}, ed);
    check({tag, ".Bout"}, {31'd0, bus.Bout}, eb);
    check({tag, ".V"}, {31'd0, bus.V}, ev);
    check({tag, ".busy_done"}, {31'd0, bus.busy}, 32'd0);
    if (mode == 2) begin
      bus.A = W'(1); bus.B = W'(1); bus.Bin = 1'b0; bus.start = 1'b1;
    end
    @(posedge clk); #1;
    bus.start = 1'b0;
    check({tag, ".done_pulse"}, {31'd0, bus.done}, 32'd0);
    check({tag, ".busy_after"}, {31'd0, bus.busy}, 32'd0);
    check({tag, ".D_hold"}, {28'd0, bus.D}, ed);
  endtask

  initial begin
    int a, b, s, ed, eb, ev;
    rst = 1'b1; bus.start = 1'b0; bus.A = '0; bus.B = '0; bus.Bin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.busy", {31'd0, bus.busy}, 0);
    check("rst.done", {31'd0, bus.done}, 0);
    check("rst.D", {28'd0, bus.D}, 0);
    check("rst.Bout", {31'd0, bus.Bout}, 0);
    check("rst.V", {31'd0, bus.V}, 0);
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("idle.busy", {31'd0, bus.busy}, 0);
    check("idle.done", {31'd0, bus.done}, 0);
    check("idle.D", {28'd0, bus.D}, 0);

    run_op(5, 3, 0, 0, "5-3");
    run_op(7, 3, 1, 0, "7-3-1");
    run_op(3, 5, 0, 0, "3-5");
    run_op(0, 0, 1, 0, "0-0-1");
    run_op(7, 8, 0, 0, "7-8");
    run_op(8, 1, 0, 0, "8-1");
    run_op(15, 0, 0, 0, "15-0");
    run_op(9, 4, 0, 1, "ign_shift");
    run_op(9, 4, 0, 2, "ign_done");

    // abort mid-operation with reset
    bus.A = W'(9); bus.B = W'(4); bus.Bin = 1'b0; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort.busy", {31'd0, bus.busy}, 0);
    check("abort.D", {28'd0, bus.D}, 0);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      check("abort.no_done", {31'd0, bus.done}, 0);
    end
    run_op(9, 4, 0, 0, "after_abort");

    for (int i = 0; i < 20; i++) begin
      a = int'($urandom_range(0, M - 1));
      b = int'($urandom_range(0, M - 1));
      run_op(a, b, int'($urandom_range(0, 1)), 0, "rand");
    end

    // add-then-subtract round trip must return the original minuend
    for (int i = 0; i < 6; i++) begin
      a = int'($urandom_range(0, M - 1));
      b = int'($urandom_range(0, M - 1));
      s = (a + b) % M;
      model(s, b, 0, ed, eb, ev);
      run_op(s, b, 0, 0, "roundtrip");
      check("roundtrip.A", {28'd0, bus.D}, a);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
